ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL use clock clk and reset rst_n, which is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  EX-stage mult/div instruction valid this cycle.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand from the ID/EX register.
REQ-007 b  input  32  rt operand from the ID/EX register.
REQ-008 hilo_rd  input  1  EX-stage MFHI/MFLO present.
REQ-009 hi_we, lo_we  input  1 each  EX-stage MTHI/MTLO.
REQ-010 wdata  input  32  MTHI/MTLO data (rs).
REQ-011 flush  input  1  kill the in-flight operation.
REQ-012 busy  output  1  operation in progress (state != IDLE).
REQ-013 stall_o  output  1  freeze IF/ID and ID/EX; bubble EX/MEM.
REQ-014 done  output  1  one-cycle pulse after HI/LO update.
REQ-015 hi_o, lo_o  output  32 each  architectural HI/LO registers.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and FIX; busy SHALL be 1 in RUN and FIX.
REQ-017 On the edge where start=1 in IDLE: latch op, latch |a| and |b| (signed ops) or a and b (unsigned ops), latch the result signs, set cnt=0, go to RUN.
REQ-018 RUN: one radix-2 iteration per edge (MUL shift-add, DIV restoring), cnt++; the edge with cnt==31 goes to FIX.
REQ-019 FIX: apply sign correction, write HI/LO, go to IDLE, set done=1 for exactly the next cycle.
REQ-020 Iterative latency SHALL be 33 busy cycles from start to HI/LO valid.
REQ-021 MULT/MULTU: {HI,LO} = the 64-bit product, two's complement for MULT.
REQ-022 DIV/DIVU: LO = quotient truncated toward zero; HI = remainder carrying the sign of a.
REQ-023 Division by zero (b==0): HI = a, LO = 32'hFFFFFFFF, with the same 33-cycle latency.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-025 stall_o = busy & (start | hilo_rd | hi_we | lo_we), combinational.
REQ-026 While busy, start, hi_we and lo_we SHALL be ignored, because the stall holds them until IDLE.
REQ-027 In IDLE, hi_we/lo_we SHALL write wdata on the edge; if start=1 on the same edge, start wins and the write is dropped.
REQ-028 flush=1 in any state SHALL force IDLE on that edge, with HI/LO unchanged, done=0 and start ignored.
REQ-029 hi_o and lo_o SHALL change only at FIX, on an MTHI/MTLO write, or at reset.

Reset
REQ-030 When rst_n=0 at an edge: state=IDLE, cnt=0, hi_o=lo_o=0, done=0, busy=0; any in-flight operation SHALL be discarded.
REQ-031 Reset SHALL take priority over flush, start and the writes.

Configuration
REQ-032 The macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
REQ-033 With MULDIV_FAST_MUL_EN defined: MULT/MULTU write HI/LO on the start edge; busy and stall_o stay 0; done pulses the next cycle; DIV is unchanged.
REQ-034 With MULDIV_FAST_MUL_EN undefined: all operations SHALL use the 33-cycle iterative path.

Verification
REQ-035 MULTU a=FFFFFFFF b=00000002 -> HI=00000001, LO=FFFFFFFE after 33 busy cycles (1 cycle with the macro).
REQ-036 MULT a=FFFFFFFD b=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB; DIVU a=7 b=2 -> LO=3, HI=1.
REQ-037 DIV a=FFFFFFF9 b=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV a=5 b=0 -> HI=5, LO=FFFFFFFF.
REQ-038 hilo_rd=1 two cycles after a DIV start -> stall_o=1 until busy falls; done=1 for exactly one cycle.
REQ-039 Preload HI=11111111 via MTHI, start DIVU, flush at cycle 10 -> busy=0 next cycle, HI=11111111, done stays 0.
REQ-040 rst_n=0 at RUN cycle 20 -> all outputs 0 on the next cycle; a new MULTU 3*4 -> LO=0000000C, HI=0.

Source files
------------

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MIPS mult/div unit with architectural HI/LO
// Define MULDIV_FAST_MUL_EN to retire MULT/MULTU in one cycle through a direct multiplier.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        stall_o,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] m;
  logic [63:0] acc;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [64:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  assign a_neg = ~op[0] & a[31];
  assign b_neg = ~op[0] & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc, 1'b0};
    div_diff  = div_shift[64:32] - {1'b0, m};
    div_next  = div_diff[32] ? div_shift[63:0] : {div_diff[31:0], div_shift[31:1], 1'b1};
  end

  always_comb begin
    prod = neg_q ? (~acc + 64'd1) : acc;
    if (is_div) begin
      res_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
      res_lo = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~acc[31:0] + 32'd1) : acc[31:0]);
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  assign ext_a     = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
  assign ext_b     = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
  assign fast_prod = ext_a * ext_b;
`endif

  assign busy    = (state != IDLE);
  assign stall_o = busy & (start | hilo_rd | hi_we | lo_we);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      hi_o     <= 32'd0;
      lo_o     <= 32'd0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      m        <= 32'd0;
      acc      <= 64'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              hi_o <= fast_prod[63:32];
              lo_o <= fast_prod[31:0];
              done <= 1'b1;
            end else
`endif
            begin
              is_div   <= op[1];
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (b == 32'd0);
              m        <= b_mag;
              acc      <= {32'd0, a_mag};
              cnt      <= 5'd0;
              state    <= RUN;
            end
          end else begin
            if (hi_we) hi_o <= wdata;
            if (lo_we) lo_o <= wdata;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          hi_o  <= res_hi;
          lo_o  <= res_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - randomized and directed checks of ex_muldiv against a behavioural model
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, hilo_rd, hi_we, lo_we, flush;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall_o, done;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .busy(busy), .stall_o(stall_o), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // {HI, LO} straight from the architectural definition
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    int qi, ri;
    case (o)
      2'd0: begin sx = longint'($signed(x)); sy = longint'($signed(y)); return 64'(sx * sy); end
      2'd1: begin ux = {32'd0, x}; uy = {32'd0, y}; return 64'(ux * uy); end
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {32'(ri), 32'(qi)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  int          m_left = 0;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done;
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_done = 0; m_valid = 1;
    end else if (flush) begin
      m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else begin
      m_done = 0;
      if (start) begin
`ifdef MULDIV_FAST_MUL_EN
        if (!op[1]) begin {m_hi, m_lo} = ref_result(op, a, b); m_done = 1; end else
`endif
        begin m_pend = ref_result(op, a, b); m_left = 33; end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",  {31'd0, busy},    {31'd0, m_left > 0});
      chk("stall", {31'd0, stall_o}, {31'd0, (m_left > 0) & (start | hilo_rd | hi_we | lo_we)});
      chk("done",  {31'd0, done},    {31'd0, m_done});
      chk("hi",    hi_o, m_hi);
      chk("lo",    lo_o, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    start = 0; op = 0; a = 0; b = 0; hilo_rd = 0; hi_we = 0; lo_we = 0; wdata = 0; flush = 0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int n;
    int exp_n;
    logic [63:0] r;
    r = ref_result(o, x, y);
    chk({nm, " model hi"}, r[63:32], ehi);
    chk({nm, " model lo"}, r[31:0], elo);
    exp_n = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) exp_n = 0;
`endif
    op = o; a = x; b = y; start = 1;
    step();
    start = 0;
    n = 0;
    for (int i = 0; i < 50 && busy; i++) begin n++; step(); end
    chk({nm, " busy cycles"}, n, exp_n);
    chk({nm, " hi"}, hi_o, ehi);
    chk({nm, " lo"}, lo_o, elo);
    chk({nm, " done pulse"}, {31'd0, done}, 32'd1);
    step();
    chk({nm, " done cleared"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int sel;
    rst_n = 0;
    clr();
    step(); step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    rst_n = 1;
    step();

    run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu max");
    run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult neg");
    run_op(2'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu 7/2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div neg");
    run_op(2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "div by zero");
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div neg by zero");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div overflow");

    // MFHI arriving mid-divide holds the stall until the result lands
    op = 2'd2; a = 32'd100; b = 32'hFFFF_FFFD; start = 1;
    step();
    start = 0;
    step();
    hilo_rd = 1;
    #1;
    chk("rd stall asserted", {31'd0, stall_o}, 32'd1);
    n = 0;
    for (int i = 0; i < 50 && busy; i++) begin n++; step(); end
    chk("rd stall cycles", n, 32);
    chk("rd stall released", {31'd0, stall_o}, 32'd0);
    chk("rd done", {31'd0, done}, 32'd1);
    chk("rd lo", lo_o, 32'hFFFF_FFDF);
    chk("rd hi", hi_o, 32'd1);
    hilo_rd = 0;
    step();
    chk("rd done once", {31'd0, done}, 32'd0);

    // flush kills a divide and leaves the MTHI value intact
    hi_we = 1; wdata = 32'h1111_1111;
    step();
    hi_we = 0;
    op = 2'd3; a = 32'd1000; b = 32'd7; start = 1;
    step();
    start = 0;
    repeat (9) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush hi", hi_o, 32'h1111_1111);
    chk("flush done", {31'd0, done}, 32'd0);
    step();
    chk("flush done later", {31'd0, done}, 32'd0);

    // reset in the middle of an operation
    op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1;
    step();
    start = 0;
    repeat (19) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst lo", lo_o, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'h0000_000C, "multu 3*4");

    // MTLO on the same edge as start is dropped
    lo_we = 1; wdata = 32'hDEAD_BEEF; op = 2'd3; a = 32'd9; b = 32'd4; start = 1;
    step();
    start = 0; lo_we = 0;
    for (int i = 0; i < 50 && busy; i++) step();
    chk("start beats mtlo", lo_o, 32'd2);

    for (int c = 0; c < 3000; c++) begin
      sel     = int'($urandom_range(0, 7));
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom);
      a       = $urandom;
      b       = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(0, 9); end
      if (sel == 3) b = 32'($signed(-int'($urandom_range(1, 9))));
      hilo_rd = ($urandom_range(0, 3) == 0);
      hi_we   = ($urandom_range(0, 5) == 0);
      lo_we   = ($urandom_range(0, 5) == 0);
      wdata   = $urandom;
      flush   = ($urandom_range(0, 79) == 0);
      rst_n   = ($urandom_range(0, 399) != 0);
      step();
    end
    clr();
    rst_n = 1;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
